lu_mat_buffer: RTL

Row-organised matrix store that sits directly upstream and downstream of the lu decomposition core. It accepts an N×N complex-double matrix from the host one row at a time. It then starts lu, serves lu's row reads with 1-cycle latency, and absorbs lu's row write-backs. It captures the L columns and U rows that lu emits, then drains them to the host as row pairs.

---
 rtl/lu_pkg.sv | 28 ++
 rtl/lu_row_ram.sv | 36 +++
 rtl/lu_mat_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared types and element helpers for the LU matrix buffer.
package lu_pkg;

  localparam int unsigned LU_SIZE  = 16;
  localparam int unsigned LU_WIDTH = 64;
  localparam int unsigned LU_ROW_W = LU_SIZE * 2 * LU_WIDTH;
  localparam int unsigned LU_AW    = $clog2(LU_SIZE);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    START   = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef logic [LU_AW-1:0]    addr_t;
  typedef logic [LU_ROW_W-1:0] row_t;

  // Element j occupies 2*WIDTH bits: real part low, imaginary part high.
  function automatic logic [LU_WIDTH-1:0] elem_re(input row_t row, input int unsigned j);
    return row[j*2*LU_WIDTH +: LU_WIDTH];
  endfunction

  function automatic logic [LU_WIDTH-1:0] elem_im(input row_t row, input int unsigned j);
    return row[j*2*LU_WIDTH+LU_WIDTH +: LU_WIDTH];
  endfunction

endpackage

// File: rtl/lu_row_ram.sv
// Row RAM: one synchronous write port, one synchronous read port, read-before-write.
module lu_row_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 2048
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DW-1:0]            rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register is cleared on reset; array contents are kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lu_mat_buffer.sv
// Matrix store feeding the LU core: host load, lu row service, L/U capture and drain.
module lu_mat_buffer
  import lu_pkg::*;
#(
  parameter int unsigned SIZE  = LU_SIZE,
  parameter int unsigned WIDTH = LU_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SIZE*2*WIDTH-1:0]   load_row_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  output logic                      lu_start_o,
  input  logic                      lu_in_ready_i,
  input  logic [$clog2(SIZE)-1:0]   rd_addr_i,
  input  logic                      rd_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0]   mat_row_o,
  output logic                      mat_row_valid_o,
  output logic [$clog2(SIZE)-1:0]   mat_row_addr_o,
  input  logic [SIZE*2*WIDTH-1:0]   wb_row_i,
  input  logic                      wb_valid_i,
  input  logic [$clog2(SIZE)-1:0]   wb_addr_i,
  output logic                      wb_ready_o,
  input  logic [SIZE*2*WIDTH-1:0]   l_col_i,
  input  logic [SIZE*2*WIDTH-1:0]   u_row_i,
  input  logic [$clog2(SIZE)-1:0]   result_addr_i,
  input  logic                      result_valid_i,
  output logic                      result_ready_o,
  output logic [SIZE*2*WIDTH-1:0]   drain_l_o,
  output logic [SIZE*2*WIDTH-1:0]   drain_u_o,
  output logic [$clog2(SIZE)-1:0]   drain_addr_o,
  output logic                      drain_valid_o,
  input  logic                      drain_ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
  localparam int unsigned AW    = $clog2(SIZE);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     load_cnt_q, load_cnt_d;
  logic [AW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [SIZE-1:0]   mask_q, mask_d;
  logic              lu_start_q, lu_start_d;
  logic              done_q, done_d;
  logic              drain_valid_q, drain_valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              load_ready_q, load_ready_d;
  logic              busy_q, busy_d;
  logic              wb_ready_q, wb_ready_d;
  logic              result_ready_q, result_ready_d;

  logic              mat_we_c;
  logic [AW-1:0]     mat_waddr_c;
  logic [ROW_W-1:0]  mat_wdata_c;
  logic              mat_re_c;
  logic              res_we_c;
  logic              dr_re_c;
  logic [AW-1:0]     dr_raddr_c;

  // Next-state, counters and RAM port control.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    mask_d        = mask_q;
    lu_start_d    = 1'b0;
    done_d        = 1'b0;
    drain_valid_d = drain_valid_q;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    mat_we_c      = 1'b0;
    mat_waddr_c   = load_cnt_q;
    mat_wdata_c   = load_row_i;
    mat_re_c      = 1'b0;
    res_we_c      = 1'b0;
    dr_re_c       = 1'b0;
    dr_raddr_c    = drain_cnt_q;

    case (state_q)
      LOAD: begin
        if (load_valid_i && load_ready_q) begin
          mat_we_c   = 1'b1;
          load_cnt_d = load_cnt_q + AW'(1);
          if (load_cnt_q == LAST) begin
            state_d = START;
          end
        end
      end
      START: begin
        if (lu_in_ready_i) begin
          lu_start_d = 1'b1;
          state_d    = COMPUTE;
        end
      end
      COMPUTE: begin
        mat_we_c    = wb_valid_i;
        mat_waddr_c = wb_addr_i;
        mat_wdata_c = wb_row_i;
        mat_re_c    = rd_addr_valid_i;
        rd_valid_d  = rd_addr_valid_i;
        if (rd_addr_valid_i) begin
          rd_addr_d = rd_addr_i;
        end
        res_we_c = result_valid_i;
        if (result_valid_i) begin
          mask_d[result_addr_i] = 1'b1;
        end
        if (&mask_q) begin
          state_d       = DRAIN;
          drain_cnt_d   = '0;
          drain_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        // First DRAIN cycle primes beat 0; each handshake prefetches the next.
        if (!drain_valid_q) begin
          dr_re_c       = 1'b1;
          drain_valid_d = 1'b1;
        end else if (drain_ready_i) begin
          if (drain_cnt_q == LAST) begin
            done_d        = 1'b1;
            drain_valid_d = 1'b0;
            drain_cnt_d   = '0;
            load_cnt_d    = '0;
            mask_d        = '0;
            state_d       = LOAD;
          end else begin
            dr_re_c     = 1'b1;
            dr_raddr_c  = drain_cnt_q + AW'(1);
            drain_cnt_d = drain_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    load_ready_d   = (state_d == LOAD);
    busy_d         = (state_d != LOAD);
    wb_ready_d     = (state_d == COMPUTE);
    result_ready_d = (state_d == COMPUTE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= LOAD;
      load_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      mask_q         <= '0;
      lu_start_q     <= 1'b0;
      done_q         <= 1'b0;
      drain_valid_q  <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_addr_q      <= '0;
      load_ready_q   <= 1'b1;
      busy_q         <= 1'b0;
      wb_ready_q     <= 1'b0;
      result_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      mask_q         <= mask_d;
      lu_start_q     <= lu_start_d;
      done_q         <= done_d;
      drain_valid_q  <= drain_valid_d;
      rd_valid_q     <= rd_valid_d;
      rd_addr_q      <= rd_addr_d;
      load_ready_q   <= load_ready_d;
      busy_q         <= busy_d;
      wb_ready_q     <= wb_ready_d;
      result_ready_q <= result_ready_d;
    end
  end

  lu_row_ram #(.DEPTH(SIZE), .DW(ROW_W)) u_mat_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (mat_we_c),
    .wr_addr_i (mat_waddr_c),
    .wr_data_i (mat_wdata_c),
    .rd_en_i   (mat_re_c),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (mat_row_o)
  );

  lu_row_ram #(.DEPTH(SIZE), .DW(ROW_W)) u_l_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (res_we_c),
    .wr_addr_i (result_addr_i),
    .wr_data_i (l_col_i),
    .rd_en_i   (dr_re_c),
    .rd_addr_i (dr_raddr_c),
    .rd_data_o (drain_l_o)
  );

  lu_row_ram #(.DEPTH(SIZE), .DW(ROW_W)) u_u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (res_we_c),
    .wr_addr_i (result_addr_i),
    .wr_data_i (u_row_i),
    .rd_en_i   (dr_re_c),
    .rd_addr_i (dr_raddr_c),
    .rd_data_o (drain_u_o)
  );

  assign load_ready_o    = load_ready_q;
  assign lu_start_o      = lu_start_q;
  assign mat_row_valid_o = rd_valid_q;
  assign mat_row_addr_o  = rd_addr_q;
  assign wb_ready_o      = wb_ready_q;
  assign result_ready_o  = result_ready_q;
  assign drain_addr_o    = drain_cnt_q;
  assign drain_valid_o   = drain_valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
